// File: rtl/az_pulse_gen.sv
// Autozero pulse generator for the synchronous front-end.
// A pulse can come from a single-shot trigger or from a free-running
// programmable period. While busy_veto is high a pulse never starts; the
// request is held in PEND and issued on the first cycle the veto is low.
// The period counter is reloaded when a pulse starts, so periodic pulses
// are spaced rising edge to rising edge, and a vetoed pulse moves the ones after it.
module az_pulse_gen #(
  parameter int CNT_W  = 12,
  parameter int WID_W  = 6,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              enable,
  input  logic [CNT_W-1:0]  period,
  input  logic [WID_W-1:0]  width,
  input  logic              trigger,
  input  logic              busy_veto,
  output logic              pulse,
  output logic [PCNT_W-1:0] pulse_cnt,
  output logic              missed
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    PEND  = 2'd2,
    PULSE = 2'd3
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WID_W-1:0]    wcnt_q;
  logic                pulse_q;
  logic                missed_q;
  logic [PCNT_W-1:0]   pcnt_q;

  logic [WID_W-1:0]    w_eff;
  logic [CNT_W-1:0]    p_load;
  logic                per_on;

  // A width of 0 still produces a one-cycle pulse.
  function automatic logic [WID_W-1:0] eff_width(input logic [WID_W-1:0] w);
    return (w == '0) ? WID_W'(1) : w;
  endfunction

  // The period is stretched to W+1 so there is always at least one low cycle.
  function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] p,
                                                  input logic [WID_W-1:0] w);
    logic [CNT_W-1:0] min_p;
    min_p = CNT_W'(w) + CNT_W'(1);
    return (p < min_p) ? min_p : p;
  endfunction

  // Effective width and period-counter load value from the current inputs.
  always_comb begin
    w_eff  = eff_width(width);
    p_load = eff_period(period, w_eff) - CNT_W'(1);
    per_on = enable && (period != '0);
  end

  // Control FSM. The pulse, missed and count outputs are all registered here.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      pulse_q  <= 1'b0;
      missed_q <= 1'b0;
      pcnt_q   <= '0;
    end else begin
      missed_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (trigger) begin
            if (!busy_veto) begin
              state_q <= PULSE;
              pulse_q <= 1'b1;
              wcnt_q  <= w_eff - WID_W'(1);
              cnt_q   <= p_load;
            end else begin
              state_q <= PEND;
            end
          end else if (per_on) begin
            state_q <= WAIT;
            cnt_q   <= p_load;
          end
        end
        WAIT: begin
          // A trigger and a period expiry on the same cycle give a single pulse.
          if (trigger || (cnt_q == '0)) begin
            if (!busy_veto) begin
              state_q <= PULSE;
              pulse_q <= 1'b1;
              wcnt_q  <= w_eff - WID_W'(1);
              cnt_q   <= p_load;
            end else begin
              state_q <= PEND;
            end
          end else if (!enable) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        PEND: begin
          // Triggers that arrive here merge into the pending request, and enable is ignored.
          if (!busy_veto) begin
            state_q <= PULSE;
            pulse_q <= 1'b1;
            wcnt_q  <= w_eff - WID_W'(1);
            cnt_q   <= p_load;
          end
        end
        PULSE: begin
          // A trigger during a pulse is dropped and flagged. The pulse is never extended.
          missed_q <= trigger;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (wcnt_q == '0) begin
            pulse_q <= 1'b0;
            pcnt_q  <= pcnt_q + PCNT_W'(1);
            if (per_on) begin
              state_q <= WAIT;
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end else begin
            wcnt_q <= wcnt_q - WID_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          pulse_q <= 1'b0;
        end
      endcase
    end
  end

  assign pulse     = pulse_q;
  assign pulse_cnt = pcnt_q;
  assign missed    = missed_q;

endmodule
